// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter in front of a single-port, word-wide data
// memory. Adds byte/halfword reads via lane extraction and sub-word stores
// via a two-cycle read-modify-write. Responses are combinational with the
// memory read path, so reads and word writes complete in the request cycle.
module dmem_arbiter #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              we0,
  input  logic [1:0]        size0,
  input  logic [31:0]       addr0,
  input  logic [31:0]       wdata0,
  output logic              gnt0,
  output logic [31:0]       rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [1:0]        size1,
  input  logic [31:0]       addr1,
  input  logic [31:0]       wdata1,
  output logic              gnt1,
  output logic [31:0]       rdata1,
  output logic              err,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_we,
  output logic [31:0]       mem_wd,
  input  logic [31:0]       mem_rd
);

  localparam logic ST_IDLE   = 1'b0;
  localparam logic ST_RMW_WR = 1'b1;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // Alignment rule: bytes anywhere, halves on even, words on 4-byte boundary.
  function automatic logic is_legal(input logic [1:0] size, input logic [1:0] lo);
    logic ok;
    case (size)
      SZ_BYTE: ok = 1'b1;
      SZ_HALF: ok = (lo[0] == 1'b0);
      SZ_WORD: ok = (lo == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Pull the addressed lane out of a memory word, zero-extended.
  function automatic logic [31:0] lane_extract(input logic [1:0] size, input logic [1:0] lo,
                                               input logic [31:0] word);
    logic [31:0] sh;
    logic [31:0] res;
    case (size)
      SZ_BYTE: begin
        sh  = word >> {lo, 3'b000};
        res = {24'd0, sh[7:0]};
      end
      SZ_HALF: begin
        sh  = word >> {lo[1], 4'b0000};
        res = {16'd0, sh[15:0]};
      end
      SZ_WORD: begin
        sh  = word;
        res = word;
      end
      default: begin
        sh  = 32'd0;
        res = 32'd0;
      end
    endcase
    return res;
  endfunction

  // Replace the addressed lane(s) of a memory word with right-aligned store data.
  function automatic logic [31:0] lane_merge(input logic [1:0] size, input logic [1:0] lo,
                                             input logic [31:0] word, input logic [31:0] wd);
    logic [31:0] mask;
    logic [31:0] ins;
    case (size)
      SZ_BYTE: begin
        mask = 32'h0000_00FF << {lo, 3'b000};
        ins  = {24'd0, wd[7:0]} << {lo, 3'b000};
      end
      SZ_HALF: begin
        mask = 32'h0000_FFFF << {lo[1], 4'b0000};
        ins  = {16'd0, wd[15:0]} << {lo[1], 4'b0000};
      end
      default: begin
        mask = 32'd0;
        ins  = 32'd0;
      end
    endcase
    return (word & ~mask) | (ins & mask);
  endfunction

  logic              r_state;
  logic              r_last;
  logic              r_owner;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_merge;

  logic              w_req;
  logic              w_sel;
  logic              w_we;
  logic [1:0]        w_size;
  logic [31:0]       w_addr;
  logic [31:0]       w_wdata;
  logic              w_unused_addr;

  logic              w_nxt_state;
  logic              w_gnt;
  logic              w_gnt_port;
  logic              w_err;
  logic [31:0]       w_rdata;
  logic [ADDR_W-1:0] w_mem_a;
  logic              w_mem_we;
  logic [31:0]       w_mem_wd;
  logic              w_start_rmw;
  logic [31:0]       w_merge;

  // Round-robin select: on conflict serve the port that was not served last.
  always_comb begin
    w_req = req0 | req1;
    w_sel = 1'b0;
    if (req0 && req1) begin
      w_sel = ~r_last;
    end else if (req1) begin
      w_sel = 1'b1;
    end else begin
      w_sel = 1'b0;
    end
    w_we          = w_sel ? we1    : we0;
    w_size        = w_sel ? size1  : size0;
    w_addr        = w_sel ? addr1  : addr0;
    w_wdata       = w_sel ? wdata1 : wdata0;
    w_unused_addr = ^w_addr[31:ADDR_W+2];
  end

  // Per-cycle access decode: completion, memory drive and next state.
  always_comb begin
    w_nxt_state = ST_IDLE;
    w_gnt       = 1'b0;
    w_gnt_port  = 1'b0;
    w_err       = 1'b0;
    w_rdata     = 32'd0;
    w_mem_a     = '0;
    w_mem_we    = 1'b0;
    w_mem_wd    = 32'd0;
    w_start_rmw = 1'b0;
    w_merge     = lane_merge(w_size, w_addr[1:0], mem_rd, w_wdata);
    if (!rst) begin
      w_nxt_state = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_req) begin
            w_mem_a    = w_addr[ADDR_W+1:2];
            w_gnt_port = w_sel;
            if (!is_legal(w_size, w_addr[1:0])) begin
              w_gnt = 1'b1;
              w_err = 1'b1;
            end else if (!w_we) begin
              w_gnt   = 1'b1;
              w_rdata = lane_extract(w_size, w_addr[1:0], mem_rd);
            end else if (w_size == SZ_WORD) begin
              w_gnt    = 1'b1;
              w_mem_we = 1'b1;
              w_mem_wd = w_wdata;
            end else begin
              // Sub-word store: read this cycle, write the merged word next.
              w_start_rmw = 1'b1;
              w_nxt_state = ST_RMW_WR;
            end
          end else begin
            w_nxt_state = ST_IDLE;
          end
        end
        ST_RMW_WR: begin
          w_mem_a     = r_addr;
          w_mem_we    = 1'b1;
          w_mem_wd    = r_merge;
          w_gnt       = 1'b1;
          w_gnt_port  = r_owner;
          w_nxt_state = ST_IDLE;
        end
        default: begin
          w_nxt_state = ST_IDLE;
        end
      endcase
    end
  end

  // Drive ports; only the completing port sees its grant and read data.
  always_comb begin
    gnt0   = w_gnt & ~w_gnt_port;
    gnt1   = w_gnt & w_gnt_port;
    rdata0 = (w_gnt && !w_gnt_port) ? w_rdata : 32'd0;
    rdata1 = (w_gnt && w_gnt_port) ? w_rdata : 32'd0;
    err    = w_err;
    mem_a  = w_mem_a;
    mem_we = w_mem_we;
    mem_wd = w_mem_wd;
  end

  // State, fairness pointer and read-modify-write latch.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_last  <= 1'b1;
      r_owner <= 1'b0;
      r_addr  <= '0;
      r_merge <= 32'd0;
    end else begin
      r_state <= w_nxt_state;
      if (w_gnt) begin
        r_last <= w_gnt_port;
      end
      if (w_start_rmw) begin
        r_merge <= w_merge;
        r_owner <= w_sel;
        r_addr  <= w_mem_a;
      end
    end
  end

endmodule
